noc_input_buffer: RTL and testbench
===================================

Name: noc_input_buffer

Overview:
- Parametrised next-generation router input-port buffer for the 4x4 mesh NoC.
- Accepts flits over a req/ack link and stores them in a FIFO of configurable width and depth.
- Arbitrates for an output port per packet (header to tail), then streams the whole packet out under the same req/ack discipline.
- Adds behaviour the current unit lacks: destination latched from the FIFO head rather than the input, single-flit packets, malformed-flit dropping with an error pulse, and an occupancy output.

Parameters:
FLIT_W, 18, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type
DEPTH, 64, FIFO entries; power of two, at least 2
DEST_W, 4, destination field width; bits [DEST_W-1:0] of a header flit
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
data_in  in  FLIT_W  incoming flit
req_in  in  1  upstream offers data_in
ack_in  out  1  buffer accepts data_in this cycle
req_port  out  FLIT_W-independent 1  request to switch allocator for port dest
grant_port  in  1  allocator grant, held high for the whole packet
dest  out  DEST_W  destination of the packet currently at the head
req_out  out  1  data_out valid toward crossbar/downstream
ack_out  in  1  downstream accepts data_out
data_out  out  FLIT_W  FIFO head flit
occupancy  out  CNT_W  number of stored flits
err  out  1  one-cycle pulse when a malformed head flit is dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Flit type encoding: 00 = header, 01 = body, 10 = tail, 11 = single (header+tail).
- Reset values: FIFO empty, occupancy=0, state=IDLE, dest=0, ack_in=0 during the reset cycle, req_port=0, req_out=0, err=0.
- Input handshake:
  - ack_in = !full, combinational; held low while rst=1.
  - A write occurs in a cycle where req_in && ack_in.
  - The flit is visible at data_out no earlier than the next cycle.
- Output handshake:
  - A pop occurs in a cycle where req_out && ack_out.
  - data_out always shows the FIFO head.
  - Simultaneous write and pop in one cycle is legal; occupancy is then unchanged.
- FIFO: read and write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; occupancy runs 0..DEPTH.
- FSM IDLE:
  - Empty FIFO: stay in IDLE.
  - Head type header or single: latch dest <= head[DEST_W-1:0], go to REQ.
  - Head type body or tail (malformed): pop it internally, err=1 for that cycle, stay in IDLE.
- FSM REQ:
  - req_port=1.
  - grant_port=1 moves to SEND next cycle.
  - dest is stable throughout REQ.
- FSM SEND:
  - req_port=1 and req_out = !empty && grant_port.
  - Popping a tail or single flit returns to IDLE next cycle; req_port drops in that IDLE cycle.
  - If the FIFO underruns mid-packet, req_out=0 and the FSM waits in SEND (wormhole stall).
  - If grant_port drops mid-packet, req_out=0 and the FSM waits in SEND. No flit is lost.
- Back-to-back packets: minimum one idle cycle between a tail pop and the next req_port assertion. The IDLE cycle evaluates the new head.
- Full boundary: at occupancy=DEPTH, ack_in=0. A pop in that cycle does not make ack_in=1 until the next cycle (no bypass).
- Reset mid-operation: a rst cycle clears state, pointers and dest regardless of handshakes in progress. Flits in flight are discarded.

Decomposition:
- Package noc_pkg holds:
  - flit-type localparams FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE;
  - FSM state encodings S_IDLE, S_REQ, S_SEND.
- Sub-module noc_flit_fifo (WIDTH, DEPTH), instantiated once:
  - inputs: push, pop;
  - outputs: full, empty, count, head.
- The FSM and dest register live in the top module.

Test Plan:
- Single 4-flit packet:
  - Stimulus: header dest=4'hA, body, body, tail; grant one cycle after req_port; ack_out=1.
  - Response: dest=A; req_port 1 until the tail pop; four data_out transfers in order; occupancy returns to 0.
- Fill to full:
  - Stimulus: req_in=1 for 70 cycles with grant_port=0.
  - Response: ack_in falls after 64 writes; occupancy=64.
  - Then grant and pop once: ack_in=1 the following cycle.
- Malformed head:
  - Stimulus: a body flit arrives while IDLE.
  - Response: err pulses for exactly 1 cycle; the flit is dropped; req_port stays 0.
- Back-to-back single-flit packets:
  - Stimulus: type 11 with dest=3, then type 11 with dest=7.
  - Response: two separate req_port episodes with dest 3 then 7; at least one idle cycle between them.
- Grant drop mid-packet:
  - Stimulus: grant_port drops after the 2nd of 4 flits, then returns.
  - Response: req_out=0 while grant is low; remaining flits are delivered intact after grant returns.
- Reset mid-packet:
  - Stimulus: rst=1 during SEND with occupancy=5.
  - Response: the next cycle shows occupancy=0, req_port=0, req_out=0, dest=0.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit type codes, FSM states and type helpers for the NoC input buffer
package noc_pkg;

   localparam logic [1:0] FLIT_HEAD   = 2'b00;
   localparam logic [1:0] FLIT_BODY   = 2'b01;
   localparam logic [1:0] FLIT_TAIL   = 2'b10;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SEND = 2'd2
   } state_t;

   // A flit that may legally open a packet.
   function automatic logic opens_packet(input logic [1:0] ftype);
      return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
   endfunction

   function automatic logic closes_packet(input logic [1:0] ftype);
      return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - circular flit FIFO with occupancy count and head-of-queue output
module noc_flit_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are exactly log2(DEPTH) wide, so wrap-around is free.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/noc_input_buffer.sv
// rtl/noc_input_buffer.sv - router input-port buffer: flit FIFO, per-packet port request, wormhole streaming
module noc_input_buffer
   import noc_pkg::*;
#(
   parameter int FLIT_W = 18,
   parameter int DEPTH  = 64,
   parameter int DEST_W = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] data_in,
   input  logic              req_in,
   output logic              ack_in,
   output logic              req_port,
   input  logic              grant_port,
   output logic [DEST_W-1:0] dest,
   output logic              req_out,
   input  logic              ack_out,
   output logic [FLIT_W-1:0] data_out,
   output logic [CNT_W-1:0]  occupancy,
   output logic              err
);

   state_t            state;
   logic [DEST_W-1:0] dest_q;
   logic              req_port_q;
   logic              full;
   logic              empty;
   logic [FLIT_W-1:0] head;
   logic [1:0]        head_type;
   logic              push;
   logic              out_pop;
   logic              drop;

   assign head_type = head[FLIT_W-1:FLIT_W-2];

   // No bypass: a pop while full only frees a slot for the following cycle.
   assign ack_in   = !full && !rst;
   assign push     = req_in && ack_in;
   assign req_out  = !rst && (state == S_SEND) && !empty && grant_port;
   assign out_pop  = req_out && ack_out;
   assign drop     = !rst && (state == S_IDLE) && !empty && !opens_packet(head_type);
   assign err      = drop;
   assign req_port = req_port_q;
   assign dest     = dest_q;
   assign data_out = head;

   noc_flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (out_pop || drop),
      .wdata (data_in),
      .full  (full),
      .empty (empty),
      .count (occupancy),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         dest_q     <= '0;
         req_port_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Destination comes from the stored head, never from data_in.
               if (!empty && opens_packet(head_type)) begin
                  dest_q     <= head[DEST_W-1:0];
                  req_port_q <= 1'b1;
                  state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (grant_port) state <= S_SEND;
            end
            S_SEND: begin
               if (out_pop && closes_packet(head_type)) begin
                  req_port_q <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               req_port_q <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb/tb_noc_input_buffer.sv - randomized and directed bench with a queue-based packet model
module tb_noc_input_buffer;

   localparam int FLIT_W = 18;
   localparam int DEPTH  = 64;
   localparam int DEST_W = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic [FLIT_W-1:0] data_in;
   logic              req_in;
   logic              ack_in;
   logic              req_port;
   logic              grant_port;
   logic [DEST_W-1:0] dest;
   logic              req_out;
   logic              ack_out;
   logic [FLIT_W-1:0] data_out;
   logic [CNT_W-1:0]  occupancy;
   logic              err;

   noc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .req_in(req_in), .ack_in(ack_in),
      .req_port(req_port), .grant_port(grant_port), .dest(dest), .req_out(req_out),
      .ack_out(ack_out), .data_out(data_out), .occupancy(occupancy), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stored flits as a queue, plus packet phase (0 idle, 1 waiting grant, 2 sending).
   logic [FLIT_W-1:0] q[$];
   int                ph = 0;
   logic [DEST_W-1:0] m_dest = '0;
   bit                m_prev_rp = 0;
   logic [FLIT_W-1:0] src[$];
   int                tx_idx = 0;
   logic [FLIT_W-1:0] out_log[$];
   logic [DEST_W-1:0] dest_log[$];
   int                err_cnt = 0;
   int                err_cyc = 0;
   int                rises = 0;
   bit                prev_dut_rp = 0;
   bit                chk_en = 0;
   bit                m_pop, m_drop, m_push;
   logic [1:0]        m_ht;

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [15:0] p);
      return {t, p};
   endfunction

   function automatic bit malformed(input logic [FLIT_W-1:0] f);
      return (f[17:16] == 2'b01) || (f[17:16] == 2'b10);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         ph        = 0;
         m_dest    = '0;
         m_prev_rp = 0;
      end else begin
         m_prev_rp = (ph != 0);
         m_ht   = (q.size() > 0) ? q[0][17:16] : 2'b00;
         m_drop = (ph == 0) && (q.size() > 0) && malformed(q[0]);
         m_pop  = (ph == 2) && (q.size() > 0) && grant_port && ack_out;
         m_push = req_in && (q.size() < DEPTH);
         if (m_drop) err_cnt++;
         if (ph == 0 && q.size() > 0 && !m_drop) begin
            m_dest = q[0][DEST_W-1:0];
            ph = 1;
            dest_log.push_back(m_dest);
         end else if (ph == 1 && grant_port) begin
            ph = 2;
         end else if (m_pop && (m_ht == 2'b10 || m_ht == 2'b11)) begin
            ph = 0;
         end
         if (m_pop) out_log.push_back(q[0]);
         if (m_pop || m_drop) void'(q.pop_front());
         if (m_push) begin
            q.push_back(data_in);
            tx_idx++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ack_in", 32'(ack_in), 32'(!rst && q.size() < DEPTH));
         chk("occupancy", 32'(occupancy), 32'(q.size()));
         chk("req_port", 32'(req_port), 32'(ph != 0));
         chk("req_out", 32'(req_out), 32'(!rst && ph == 2 && q.size() > 0 && grant_port));
         chk("err", 32'(err), 32'(!rst && ph == 0 && q.size() > 0 && malformed(q[0])));
         chk("dest", 32'(dest), 32'(m_dest));
         if (q.size() > 0) chk("data_out", 32'(data_out), 32'(q[0]));
         if (req_port && !prev_dut_rp) rises++;
         prev_dut_rp = req_port;
         if (err) err_cyc++;
      end
   end

   // gmode: 0 low, 1 high, 2 random, 3 one cycle after req_port
   task automatic step(input int p_req, input int p_ack, input int gmode);
      req_in  = (tx_idx < src.size()) && ($urandom_range(99) < p_req);
      data_in = (tx_idx < src.size()) ? src[tx_idx] : FLIT_W'($urandom);
      ack_out = ($urandom_range(99) < p_ack);
      case (gmode)
         0:       grant_port = 1'b0;
         1:       grant_port = 1'b1;
         2:       grant_port = ($urandom_range(99) < 70);
         default: grant_port = m_prev_rp;
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic run_n(input int n, input int p_req, input int p_ack, input int gmode);
      for (int i = 0; i < n; i++) step(p_req, p_ack, gmode);
   endtask

   task automatic run_to(input int want, input bit need_idle, input int max,
                         input int p_req, input int p_ack, input int gmode);
      int k = 0;
      while (!(out_log.size() >= want && (!need_idle || ph == 0)) && k < max) begin
         step(p_req, p_ack, gmode);
         k++;
      end
      if (k >= max) begin
         total++;
         bad++;
         $display("FAIL run_to timeout: got %0d flits expected %0d", out_log.size(), want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_in = 1'b0; ack_out = 1'b0; grant_port = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      src.delete(); out_log.delete(); dest_log.delete();
      tx_idx = 0; err_cnt = 0; err_cyc = 0; rises = 0;
   endtask

   initial begin
      rst = 1'b1; req_in = 1'b0; ack_out = 1'b0; grant_port = 1'b0; data_in = '0;
      @(posedge clk); #1;
      chk_en = 1;
      do_reset();
      chk("reset occupancy", 32'(occupancy), 32'd0);
      chk("reset req_port", 32'(req_port), 32'd0);
      chk("reset dest", 32'(dest), 32'd0);

      // single 4-flit packet to dest A
      src = '{mk(2'b00, 16'h120A), mk(2'b01, 16'h1111), mk(2'b01, 16'h2222), mk(2'b10, 16'h3333)};
      run_to(4, 1, 40, 100, 100, 3);
      chk("pkt1 count", 32'(out_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < out_log.size(); i++) chk("pkt1 order", 32'(out_log[i]), 32'(src[i]));
      chk("pkt1 dest", 32'(dest), 32'hA);
      chk("pkt1 occupancy", 32'(occupancy), 32'd0);
      chk("pkt1 episodes", 32'(rises), 32'd1);

      // fill to full with no grant, then a single pop
      do_reset();
      src.push_back(mk(2'b00, 16'h0001));
      for (int i = 1; i < 70; i++) src.push_back(mk(2'b01, 16'(i)));
      run_n(70, 100, 0, 0);
      chk("full occupancy", 32'(occupancy), 32'd64);
      chk("full ack_in", 32'(ack_in), 32'd0);
      chk("full writes", 32'(tx_idx), 32'd64);
      run_to(1, 0, 10, 0, 100, 1);
      ack_out = 1'b0;
      chk("after pop ack_in", 32'(ack_in), 32'd1);
      chk("after pop occupancy", 32'(occupancy), 32'd63);

      // malformed head while idle
      do_reset();
      src = '{mk(2'b01, 16'h0055)};
      run_n(6, 100, 100, 2);
      chk("malformed err count", 32'(err_cnt), 32'd1);
      chk("malformed err cycles", 32'(err_cyc), 32'd1);
      chk("malformed occupancy", 32'(occupancy), 32'd0);
      chk("malformed episodes", 32'(rises), 32'd0);

      // back-to-back single-flit packets
      do_reset();
      src = '{mk(2'b11, 16'h0003), mk(2'b11, 16'h0007)};
      run_to(2, 1, 40, 100, 100, 3);
      chk("singles episodes", 32'(rises), 32'd2);
      chk("singles dests", 32'(dest_log.size()), 32'd2);
      if (dest_log.size() == 2) begin
         chk("single dest0", 32'(dest_log[0]), 32'd3);
         chk("single dest1", 32'(dest_log[1]), 32'd7);
      end

      // grant drop after the second flit
      do_reset();
      src = '{mk(2'b00, 16'h0005), mk(2'b01, 16'hAAAA), mk(2'b01, 16'hBBBB), mk(2'b10, 16'hCCCC)};
      run_to(2, 0, 40, 100, 100, 1);
      run_n(5, 100, 100, 0);
      chk("grant low no flits", 32'(out_log.size()), 32'd2);
      run_to(4, 1, 40, 100, 100, 1);
      for (int i = 0; i < 4 && i < out_log.size(); i++) chk("grant drop order", 32'(out_log[i]), 32'(src[i]));

      // reset in the middle of a packet
      do_reset();
      src.push_back(mk(2'b00, 16'h0009));
      for (int i = 0; i < 8; i++) src.push_back(mk(2'b01, 16'(i)));
      src.push_back(mk(2'b10, 16'hEEEE));
      run_n(12, 100, 0, 0);
      run_to(5, 0, 20, 0, 100, 1);
      chk("pre-reset occupancy", 32'(occupancy), 32'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; grant_port = 1'b0; ack_out = 1'b0;
      chk("post-reset occupancy", 32'(occupancy), 32'd0);
      chk("post-reset req_port", 32'(req_port), 32'd0);
      chk("post-reset req_out", 32'(req_out), 32'd0);
      chk("post-reset dest", 32'(dest), 32'd0);

      // random packet traffic with occasional stray body flits
      do_reset();
      for (int p = 0; p < 300; p++) begin
         int len = $urandom_range(1, 5);
         if ($urandom_range(99) < 5) src.push_back(mk(2'b01, 16'($urandom)));
         if (len == 1) src.push_back(mk(2'b11, 16'($urandom)));
         else begin
            src.push_back(mk(2'b00, 16'($urandom)));
            for (int b = 0; b < len - 2; b++) src.push_back(mk(2'b01, 16'($urandom)));
            src.push_back(mk(2'b10, 16'($urandom)));
         end
      end
      run_n(3000, 70, 70, 2);
      for (int k = 0; k < 5000 && !(tx_idx == src.size() && q.size() == 0 && ph == 0); k++)
         step(100, 100, 1);
      chk("random drained", 32'(q.size() == 0 && tx_idx == src.size()), 32'd1);
      chk("random occupancy", 32'(occupancy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
